// File: rtl/serial_cipher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_cipher_pkg
// Brief    : Shared state encoding, sizes and helpers for the serial cipher.
// Revision : 1.0 - initial release
// ============================================================================
package serial_cipher_pkg;

  localparam int BYTE_BITS      = 8;
  localparam int DEF_STATE_BITS = 128;
  localparam int DEF_NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  function automatic int cnt_width(input int bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : serial_bit_counter
// Brief    : Modulo-MODULUS bit counter with clear, enable and wrap strobe.
// Revision : 1.0 - initial release
// ============================================================================
module serial_bit_counter #(
  parameter int MODULUS = 128,
  parameter int WIDTH   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_cnt;

  assign wrap = en && (r_cnt == c_last);
  assign cnt  = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || wrap) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_round_ctrl
// Brief    : Load/round/unload sequencer for the bit-serial cipher shift stage.
// Revision : 1.0 - initial release
// ============================================================================
module serial_round_ctrl
  import serial_cipher_pkg::*;
#(
  parameter int NUM_ROUNDS = serial_cipher_pkg::DEF_NUM_ROUNDS,
  parameter int STATE_BITS = serial_cipher_pkg::DEF_STATE_BITS,
  parameter int BYTE_BITS  = serial_cipher_pkg::BYTE_BITS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  output logic                             in_ready,
  output logic                             in_sel,
  output logic                             ctrl_sbox,
  output logic                             mix_en,
  output logic                             last_round,
  output logic [3:0]                       round_idx,
  output logic [cnt_width(STATE_BITS)-1:0] bit_cnt,
  output logic                             dout_valid,
  output logic                             busy,
  output logic                             done
);

  localparam int         c_cw         = cnt_width(STATE_BITS);
  localparam int         c_byte_w     = $clog2(BYTE_BITS);
  localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_round, w_round_nxt;
  logic             r_done,  w_done_nxt;
  logic [c_cw-1:0]  w_bit_cnt;
  logic             w_wrap;
  logic             w_busy;

  assign w_busy = (r_state != ST_IDLE);

  serial_bit_counter #(
    .MODULUS (STATE_BITS),
    .WIDTH   (c_cw)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort && w_busy),
    .en   (w_busy),
    .cnt  (w_bit_cnt),
    .wrap (w_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_round <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_done_nxt  = 1'b0;
    if (w_busy && abort) begin
      w_state_nxt = ST_IDLE;
      w_round_nxt = 4'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) w_state_nxt = ST_LOAD;
        end
        ST_LOAD: begin
          if (w_wrap) begin
            w_state_nxt = ST_ROUND;
            w_round_nxt = 4'd1;
          end
        end
        ST_ROUND: begin
          if (w_wrap) begin
            if (r_round == c_last_round) begin
              w_state_nxt = ST_OUT;
              w_round_nxt = 4'd0;
            end else begin
              w_round_nxt = r_round + 4'd1;
            end
          end
        end
        ST_OUT: begin
          if (w_wrap) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_round_nxt = 4'd0;
        end
      endcase
    end
  end

  // The first byte boundary of round 1 has no assembled byte yet; the final
  // round's last byte is substituted on the first OUT cycle instead.
  always_comb begin
    ctrl_sbox = 1'b0;
    if (r_state == ST_ROUND) begin
      ctrl_sbox = (w_bit_cnt[c_byte_w-1:0] == '0) &&
                  !((r_round == 4'd1) && (w_bit_cnt == '0));
    end else if (r_state == ST_OUT) begin
      ctrl_sbox = (w_bit_cnt == '0);
    end
  end

  assign in_ready   = (r_state == ST_LOAD);
  assign in_sel     = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign mix_en     = (r_state == ST_ROUND) && (r_round < c_last_round);
  assign last_round = (r_state == ST_ROUND) && (r_round == c_last_round);
  assign round_idx  = r_round;
  assign bit_cnt    = w_bit_cnt;
  assign dout_valid = (r_state == ST_OUT);
  assign busy       = w_busy;
  assign done       = r_done;

endmodule
`default_nettype wire
